// File: rtl/nx_ram_sched_pkg.sv
// Shared types and helpers for the single-port RAM scheduler.
package nx_ram_sched_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

    // Round-robin pick over up to 8 requesters: search upward from ptr with
    // wrap at n, first set bit wins. Returns a one-hot vector (all zero if none).
    function automatic logic [7:0] rr_pick(
        input logic [7:0]  vld,
        input logic [2:0]  ptr,
        input int unsigned n
    );
        logic [7:0] gnt;
        logic       found;
        logic [2:0] idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < n) begin
                idx = 3'(({29'b0, ptr} + k) % n);
                if (!found && vld[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/nx_ram_1rw_sched_arb.sv
// Combinational round-robin arbiter: one-hot grant plus encoded winner index.
module nx_rr_arb
    import nx_ram_sched_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] vld,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx,
    output logic               gnt_any
);

    logic [7:0] vld_ext;
    logic [2:0] ptr_ext;
    logic [7:0] gnt_ext;

    // Widen to the helper's fixed 8-lane form and pick the winner.
    always_comb begin
        vld_ext              = '0;
        vld_ext[NUM_REQ-1:0] = vld;
        ptr_ext              = '0;
        ptr_ext[IW-1:0]      = ptr;
        gnt_ext              = rr_pick(vld_ext, ptr_ext, NUM_REQ);
        gnt                  = gnt_ext[NUM_REQ-1:0];
        gnt_any              = |gnt_ext;
    end

    // One-hot to binary encode of the winner.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/nx_ram_1rw_sched.sv
// Zero-fill sequencer and round-robin port sharer in front of a 1RW RAM.
module nx_ram_1rw_sched
    import nx_ram_sched_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    parameter  int WIDTH   = 38,
    parameter  int DEPTH   = 16384,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_req,
    output logic                     init_done,
    input  logic [NUM_REQ-1:0]       req_vld,
    input  logic [NUM_REQ-1:0]       req_we,
    input  logic [NUM_REQ*AW-1:0]    req_add,
    input  logic [NUM_REQ*WIDTH-1:0] req_din,
    input  logic [NUM_REQ*WIDTH-1:0] req_bwe,
    output logic [NUM_REQ-1:0]       req_rdy,
    output logic [NUM_REQ-1:0]       rsp_vld,
    output logic [WIDTH-1:0]         rsp_dat,
    output logic                     ram_cs,
    output logic                     ram_we,
    output logic [AW-1:0]            ram_add,
    output logic [WIDTH-1:0]         ram_din,
    output logic [WIDTH-1:0]         ram_bwe,
    input  logic [WIDTH-1:0]         ram_dout
);

    localparam int IW = $clog2(NUM_REQ);

    sched_state_e       state_reg;
    logic [AW-1:0]      init_add_reg;
    logic [IW-1:0]      rr_ptr_reg;
    logic [NUM_REQ-1:0] rsp_vld_reg;
    logic               init_done_reg;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic               grant_en;
    logic [IW-1:0]      rr_ptr_next;

    logic [AW-1:0]      add_arr [NUM_REQ];
    logic [WIDTH-1:0]   din_arr [NUM_REQ];
    logic [WIDTH-1:0]   bwe_arr [NUM_REQ];

    // Unpack the per-requester fields so the winner can be selected by index.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign add_arr[gi] = req_add[gi*AW +: AW];
        assign din_arr[gi] = req_din[gi*WIDTH +: WIDTH];
        assign bwe_arr[gi] = req_bwe[gi*WIDTH +: WIDTH];
    end

    nx_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .vld     (req_vld),
        .ptr     (rr_ptr_reg),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // Grants only exist in RUN and never while reset is asserted.
    assign grant_en    = (state_reg == RUN) && !rst;
    assign req_rdy     = grant_en ? arb_gnt : '0;
    assign rr_ptr_next = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);

    // Outputs are masked during reset so a stale response or done flag never leaks.
    assign init_done = init_done_reg & ~rst;
    assign rsp_vld   = rst ? '0 : rsp_vld_reg;
    assign rsp_dat   = ram_dout;

    // RAM port mux: fill writes in INIT, the granted requester's fields in RUN.
    always_comb begin
        ram_cs  = 1'b0;
        ram_we  = 1'b0;
        ram_add = '0;
        ram_din = '0;
        ram_bwe = '0;
        if (state_reg == INIT) begin
            ram_cs  = !rst;
            ram_we  = 1'b1;
            ram_add = init_add_reg;
            ram_bwe = '1;
        end else if (grant_en && arb_any) begin
            ram_cs  = 1'b1;
            ram_we  = req_we[arb_idx];
            ram_add = add_arr[arb_idx];
            ram_din = din_arr[arb_idx];
            ram_bwe = bwe_arr[arb_idx];
        end
    end

    // Sequencer FSM, fill counter, fairness pointer and read-response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= INIT;
            init_add_reg  <= '0;
            rr_ptr_reg    <= '0;
            rsp_vld_reg   <= '0;
            init_done_reg <= 1'b0;
        end else begin
            // A granted read answers one cycle later; this also covers a read
            // granted alongside init_req, whose answer lands in the first INIT cycle.
            rsp_vld_reg <= req_rdy & ~req_we;
            case (state_reg)
                INIT: begin
                    init_add_reg <= init_add_reg + AW'(1);
                    if (init_add_reg == AW'(DEPTH - 1)) begin
                        state_reg     <= RUN;
                        init_done_reg <= 1'b1;
                        init_add_reg  <= '0;
                    end
                end
                RUN: begin
                    if (arb_any) begin
                        rr_ptr_reg <= rr_ptr_next;
                    end
                    if (init_req) begin
                        state_reg     <= INIT;
                        init_add_reg  <= '0;
                        init_done_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nx_ram_1rw_sched.sv
// Directed self-checking bench for nx_ram_1rw_sched with a small behavioural RAM.
module tb_nx_ram_1rw_sched;

    localparam int NUM_REQ = 3;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     init_req;
    logic                     init_done;
    logic [NUM_REQ-1:0]       req_vld;
    logic [NUM_REQ-1:0]       req_we;
    logic [NUM_REQ*AW-1:0]    req_add;
    logic [NUM_REQ*WIDTH-1:0] req_din;
    logic [NUM_REQ*WIDTH-1:0] req_bwe;
    logic [NUM_REQ-1:0]       req_rdy;
    logic [NUM_REQ-1:0]       rsp_vld;
    logic [WIDTH-1:0]         rsp_dat;
    logic                     ram_cs;
    logic                     ram_we;
    logic [AW-1:0]            ram_add;
    logic [WIDTH-1:0]         ram_din;
    logic [WIDTH-1:0]         ram_bwe;
    logic [WIDTH-1:0]         ram_dout = '0;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    nx_ram_1rw_sched #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init_req  (init_req),
        .init_done (init_done),
        .req_vld   (req_vld),
        .req_we    (req_we),
        .req_add   (req_add),
        .req_din   (req_din),
        .req_bwe   (req_bwe),
        .req_rdy   (req_rdy),
        .rsp_vld   (rsp_vld),
        .rsp_dat   (rsp_dat),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_add   (ram_add),
        .ram_din   (ram_din),
        .ram_bwe   (ram_bwe),
        .ram_dout  (ram_dout)
    );

    // Single-port RAM stand-in: bit-masked write, registered read.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_add] <= (mem[ram_add] & ~ram_bwe) | (ram_din & ram_bwe);
            else        ram_dout <= mem[ram_add];
        end
    end

    // One line per granted access and per read response.
    always @(negedge clk) begin
        #2;
        if (|req_rdy) $display("txn t=%0t grant=%b we=%b add=%0d din=%h bwe=%h", $time, req_rdy, ram_we, ram_add, ram_din, ram_bwe);
        if (|rsp_vld) $display("txn t=%0t rsp=%b dat=%h", $time, rsp_vld, rsp_dat);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst = 1'b1; init_req = 1'b0; req_vld = '0; req_we = '0;
        req_add = '0; req_din = '0; req_bwe = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            total++; if (ram_cs !== 1'b0) begin bad++; $display("FAIL reset_cs got=%b want=0", ram_cs); end
            total++; if (req_rdy !== 3'b000) begin bad++; $display("FAIL reset_rdy got=%b want=000", req_rdy); end
            total++; if (rsp_vld !== 3'b000) begin bad++; $display("FAIL reset_rsp got=%b want=000", rsp_vld); end
            total++; if (init_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", init_done); end
        end
        // Release; requesters already asking must be held off during the fill.
        rst = 1'b0; req_vld = 3'b111;
        for (int i = 0; i < DEPTH; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            total++; if (ram_cs !== 1'b1 || ram_we !== 1'b1) begin bad++; $display("FAIL fill_cswe i=%0d got=%b%b want=11", i, ram_cs, ram_we); end
            total++; if (ram_add !== AW'(i)) begin bad++; $display("FAIL fill_add got=%0d want=%0d", ram_add, i); end
            total++; if (ram_din !== 8'h00 || ram_bwe !== 8'hFF) begin bad++; $display("FAIL fill_data i=%0d got din=%h bwe=%h want 00/ff", i, ram_din, ram_bwe); end
            total++; if (req_rdy !== 3'b000) begin bad++; $display("FAIL fill_rdy i=%0d got=%b want=000", i, req_rdy); end
            total++; if (init_done !== 1'b0) begin bad++; $display("FAIL fill_done i=%0d got=%b want=0", i, init_done); end
        end
        @(negedge clk); req_vld = '0; #1;
        total++; if (init_done !== 1'b1) begin bad++; $display("FAIL init_done_rise got=%b want=1", init_done); end
        total++; if (ram_cs !== 1'b0) begin bad++; $display("FAIL idle_cs got=%b want=0", ram_cs); end
    endtask

    task automatic test_read;
        @(negedge clk);
        req_vld = 3'b001; req_we = 3'b000; req_add[0*AW +: AW] = 4'd5; #1;
        total++; if (req_rdy !== 3'b001) begin bad++; $display("FAIL read_rdy got=%b want=001", req_rdy); end
        total++; if (ram_cs !== 1'b1 || ram_we !== 1'b0 || ram_add !== 4'd5) begin bad++; $display("FAIL read_ram got cs=%b we=%b add=%0d want 1/0/5", ram_cs, ram_we, ram_add); end
        @(negedge clk); req_vld = '0; #1;
        total++; if (rsp_vld !== 3'b001) begin bad++; $display("FAIL read_rsp got=%b want=001", rsp_vld); end
        total++; if (rsp_dat !== 8'h00) begin bad++; $display("FAIL read_dat got=%h want=00", rsp_dat); end
    endtask

    task automatic test_write_read;
        @(negedge clk);
        req_vld = 3'b010; req_we = 3'b010; req_add[1*AW +: AW] = 4'd3;
        req_din[1*WIDTH +: WIDTH] = 8'hA5; req_bwe[1*WIDTH +: WIDTH] = 8'h0F; #1;
        total++; if (req_rdy !== 3'b010) begin bad++; $display("FAIL wr_rdy got=%b want=010", req_rdy); end
        total++; if (ram_we !== 1'b1 || ram_add !== 4'd3 || ram_din !== 8'hA5 || ram_bwe !== 8'h0F) begin bad++; $display("FAIL wr_ram got we=%b add=%0d din=%h bwe=%h want 1/3/a5/0f", ram_we, ram_add, ram_din, ram_bwe); end
        @(negedge clk); req_we = 3'b000; #1;
        total++; if (req_rdy !== 3'b010 || ram_we !== 1'b0) begin bad++; $display("FAIL rd3_grant got rdy=%b we=%b want 010/0", req_rdy, ram_we); end
        total++; if (rsp_vld !== 3'b000) begin bad++; $display("FAIL wr_norsp got=%b want=000", rsp_vld); end
        @(negedge clk); req_vld = '0; #1;
        total++; if (rsp_vld !== 3'b010) begin bad++; $display("FAIL rd3_rsp got=%b want=010", rsp_vld); end
        total++; if (rsp_dat !== 8'h05) begin bad++; $display("FAIL rd3_dat got=%h want=05", rsp_dat); end
    endtask

    task automatic test_round_robin;
        logic [2:0] vld_seq [9] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b101, 3'b101, 3'b101};
        logic [2:0] exp_seq [9] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
        logic [2:0] prev;
        // Pointer sits at 2 now; one grant to req2 brings it back to 0.
        @(negedge clk);
        req_vld = 3'b100; req_we = 3'b000;
        req_add[0*AW +: AW] = 4'd3; req_add[1*AW +: AW] = 4'd7; req_add[2*AW +: AW] = 4'd9; #1;
        total++; if (req_rdy !== 3'b100) begin bad++; $display("FAIL rr_align got=%b want=100", req_rdy); end
        prev = 3'b100;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk); req_vld = vld_seq[k]; #1;
            total++; if (req_rdy !== exp_seq[k]) begin bad++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, req_rdy, exp_seq[k]); end
            total++; if (rsp_vld !== prev) begin bad++; $display("FAIL rr_rsp k=%0d got=%b want=%b", k, rsp_vld, prev); end
            total++; if (rsp_dat !== ((prev == 3'b001) ? 8'h05 : 8'h00)) begin bad++; $display("FAIL rr_dat k=%0d got=%h want=%h", k, rsp_dat, (prev == 3'b001) ? 8'h05 : 8'h00); end
            prev = exp_seq[k];
        end
        @(negedge clk); req_vld = '0; #1;
        total++; if (rsp_vld !== 3'b001 || rsp_dat !== 8'h05) begin bad++; $display("FAIL rr_last got=%b/%h want=001/05", rsp_vld, rsp_dat); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        req_vld = 3'b001; req_we = 3'b001; req_add[0*AW +: AW] = 4'd9;
        req_din[0*WIDTH +: WIDTH] = 8'h3C; req_bwe[0*WIDTH +: WIDTH] = 8'hFF; #1;
        total++; if (req_rdy !== 3'b001 || ram_we !== 1'b1) begin bad++; $display("FAIL b2b_wr got rdy=%b we=%b want 001/1", req_rdy, ram_we); end
        @(negedge clk); req_we = 3'b000; #1;
        total++; if (req_rdy !== 3'b001 || ram_we !== 1'b0) begin bad++; $display("FAIL b2b_rd got rdy=%b we=%b want 001/0", req_rdy, ram_we); end
        @(negedge clk); req_vld = '0; #1;
        total++; if (rsp_vld !== 3'b001 || rsp_dat !== 8'h3C) begin bad++; $display("FAIL b2b_rsp got=%b/%h want=001/3c", rsp_vld, rsp_dat); end
    endtask

    task automatic test_init_req;
        @(negedge clk);
        req_vld = 3'b100; req_we = 3'b000; req_add[2*AW +: AW] = 4'd9; init_req = 1'b1; #1;
        total++; if (req_rdy !== 3'b100 || ram_cs !== 1'b1 || ram_we !== 1'b0) begin bad++; $display("FAIL ireq_grant got rdy=%b cs=%b we=%b want 100/1/0", req_rdy, ram_cs, ram_we); end
        @(negedge clk); init_req = 1'b0; req_vld = 3'b111; #1;
        total++; if (rsp_vld !== 3'b100 || rsp_dat !== 8'h3C) begin bad++; $display("FAIL ireq_rsp got=%b/%h want=100/3c", rsp_vld, rsp_dat); end
        total++; if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_add !== 4'd0) begin bad++; $display("FAIL refill_start got cs=%b we=%b add=%0d want 1/1/0", ram_cs, ram_we, ram_add); end
        total++; if (init_done !== 1'b0 || req_rdy !== 3'b000) begin bad++; $display("FAIL refill_gate got done=%b rdy=%b want 0/000", init_done, req_rdy); end
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk); init_req = (i == 5); #1;
            total++; if (ram_add !== AW'(i)) begin bad++; $display("FAIL refill_add got=%0d want=%0d", ram_add, i); end
            total++; if (init_done !== 1'b0 || req_rdy !== 3'b000) begin bad++; $display("FAIL refill_hold i=%0d got done=%b rdy=%b want 0/000", i, init_done, req_rdy); end
        end
        @(negedge clk); init_req = 1'b0; req_vld = '0; #1;
        total++; if (init_done !== 1'b1) begin bad++; $display("FAIL refill_done got=%b want=1", init_done); end
        @(negedge clk); req_vld = 3'b001; req_add[0*AW +: AW] = 4'd9; #1;
        total++; if (req_rdy !== 3'b001) begin bad++; $display("FAIL refill_rd got=%b want=001", req_rdy); end
        @(negedge clk); req_vld = '0; #1;
        total++; if (rsp_vld !== 3'b001 || rsp_dat !== 8'h00) begin bad++; $display("FAIL refill_clear got=%b/%h want=001/00", rsp_vld, rsp_dat); end
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
        req_vld = 3'b001; req_we = 3'b000; req_add[0*AW +: AW] = 4'd3; #1;
        total++; if (req_rdy !== 3'b001) begin bad++; $display("FAIL mid_grant got=%b want=001", req_rdy); end
        @(negedge clk); req_vld = '0; rst = 1'b1; #1;
        total++; if (rsp_vld !== 3'b000 || ram_cs !== 1'b0) begin bad++; $display("FAIL mid_drop got rsp=%b cs=%b want 000/0", rsp_vld, ram_cs); end
        @(negedge clk); rst = 1'b0; #1;
        total++; if (rsp_vld !== 3'b000 || init_done !== 1'b0) begin bad++; $display("FAIL mid_after got rsp=%b done=%b want 000/0", rsp_vld, init_done); end
        total++; if (ram_cs !== 1'b1 || ram_add !== 4'd0) begin bad++; $display("FAIL mid_refill got cs=%b add=%0d want 1/0", ram_cs, ram_add); end
        repeat (DEPTH) @(negedge clk);
        #1;
        total++; if (init_done !== 1'b1) begin bad++; $display("FAIL mid_done got=%b want=1", init_done); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hEE;
        test_reset();
        test_read();
        test_write_read();
        test_round_robin();
        test_back_to_back();
        test_init_req();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nx_ram_1rw_sched.md
Name: nx_ram_1rw_sched

Overview:
- Sequencer and round-robin arbiter in front of one single-port, 1-cycle-read-latency RAM macro with byte/bit write enables (nx_ram_1rw family).
- After reset, or on request, it zero-fills every RAM location.
- It then shares the single port among NUM_REQ requesters: one access per cycle, fair rotation, and read data returned with a per-requester valid.
- Sits between engine-side table/history clients and the RAM wrapper.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- WIDTH, 38, RAM data width; the write-enable vector is the same width.
- DEPTH, 16384, RAM word count.
- AW, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- init_req  in  1  pulse; restarts the zero-fill.
- init_done  out  1  high when the fill is complete and requests are accepted.
- req_vld  in  NUM_REQ  per-requester access valid.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_add  in  NUM_REQ*AW  packed addresses; requester i occupies [i*AW +: AW].
- req_din  in  NUM_REQ*WIDTH  packed write data.
- req_bwe  in  NUM_REQ*WIDTH  packed bit write enables.
- req_rdy  out  NUM_REQ  one-hot grant; an access transfers when vld and rdy are both high.
- rsp_vld  out  NUM_REQ  one-hot; read data valid for that requester.
- rsp_dat  out  WIDTH  read data, pass-through of ram_dout.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write.
- ram_add  out  AW  RAM address.
- ram_din  out  WIDTH  RAM write data.
- ram_bwe  out  WIDTH  RAM bit enables.
- ram_dout  in  WIDTH  RAM registered read data; valid 1 cycle after cs with we=0.

Behaviour:
- Single clock; reset is synchronous, active-high.
- While rst is high, or on the first cycle after it:
  - state=INIT, init_add=0, rr_ptr=0, rsp_vld=0, init_done=0.
  - req_rdy=0, and ram_* follow the INIT rule below.
- While rst is high, ram_cs=0.
- FSM states: INIT and RUN.
- INIT:
  - Each cycle: ram_cs=1, ram_we=1, ram_add=init_add, ram_din=0, ram_bwe=all ones.
  - init_add increments each cycle.
  - When init_add==DEPTH-1 the write completes and the next state is RUN with init_done=1.
  - The fill takes exactly DEPTH cycles.
  - req_rdy=0 throughout.
  - init_req during INIT is ignored.
- RUN:
  - Grant is combinational. Search req_vld starting at index rr_ptr upward, with wrap; the first set bit wins, and req_rdy = onehot(winner).
  - No vld means no grant and ram_cs=0.
  - On a grant to requester g: ram_cs=1, ram_we=req_we[g], and ram_add/ram_din/ram_bwe are requester g's fields, all in the same cycle.
  - rr_ptr becomes (g+1) mod NUM_REQ on a grant; otherwise it holds.
- Read response:
  - When a read is granted to g in cycle t, rsp_vld[g]=1 in cycle t+1 (registered), with rsp_dat=ram_dout.
  - There is no backpressure on responses; a requester must sink rsp_vld.
  - Writes produce no response.
- Back-to-back ordering:
  - The RAM is single-port; a read at cycle t+1 after a write at cycle t to the same address returns the new data.
  - The scheduler adds no reordering.
- init_req in RUN:
  - Next state is INIT; init_add=0 and init_done drops on the next cycle.
  - A grant in the same cycle as init_req still completes.
  - A read granted in the cycle before INIT still delivers rsp_vld in the first INIT cycle.
- Reset mid-operation: an in-flight read response is dropped (rsp_vld forced to 0), and the fill restarts from address 0.
- The requester must hold req_* stable while vld is high and rdy is low.
- Addresses are passed unmodified; an address >= DEPTH is the requester's error and is not checked.

Decomposition:
- Package nx_ram_sched_pkg holds:
  - typedef enum logic {INIT, RUN} sched_state_e;
  - a function to compute a round-robin one-hot winner from (vld, ptr).
- Sub-module nx_rr_arb (NUM_REQ): inputs vld, ptr; output onehot grant and encoded index.
- The top level holds the FSM, init counter, rr_ptr, the response register, and the field muxes.

Test Plan (DEPTH=16, WIDTH=8, NUM_REQ=3):
- Reset 2 cycles, then release → ram_cs=1/we=1/din=0 for 16 consecutive cycles at addresses 0..15; init_done rises in cycle 17; req_rdy=0 throughout.
- After init, req0 reads address 5 → req_rdy[0] same cycle; rsp_vld=3'b001 next cycle with rsp_dat=8'h00.
- req1 writes 8'hA5 to address 3 with bwe=8'h0F, then reads address 3 → rsp_vld[1] with rsp_dat=8'h05.
- req_vld=3'b111 held for 6 cycles → grants 001,010,100,001,010,100; then vld=3'b101 with rr_ptr=0 → 001,100,001.
- Read granted to req2 in the same cycle as init_req → rsp_vld[2]=1 next cycle; then a 16-cycle fill; init_done low for 16 cycles.
- rst asserted in the cycle after a read grant → rsp_vld stays 0; the fill restarts at address 0.
